fft_frame_serializer: RTL and testbench

//  Downstream consumer of the FAS FFT outputs. It captures each 16-bin FFT frame,

---
 rtl/fft_frame_serializer.sv | 151 +++++++++++++++
 tb/tb_fft_frame_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_serializer.sv
// rtl/fft_frame_serializer.sv - captures 16-bin FFT frames and replays them bin-by-bin on a valid/ready stream
module fft_frame_serializer #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fft_valid,
  input  logic [DW-1:0]    fft_d0,
  input  logic [DW-1:0]    fft_d1,
  input  logic [DW-1:0]    fft_d2,
  input  logic [DW-1:0]    fft_d3,
  input  logic [DW-1:0]    fft_d4,
  input  logic [DW-1:0]    fft_d5,
  input  logic [DW-1:0]    fft_d6,
  input  logic [DW-1:0]    fft_d7,
  input  logic [DW-1:0]    fft_d8,
  input  logic [DW-1:0]    fft_d9,
  input  logic [DW-1:0]    fft_d10,
  input  logic [DW-1:0]    fft_d11,
  input  logic [DW-1:0]    fft_d12,
  input  logic [DW-1:0]    fft_d13,
  input  logic [DW-1:0]    fft_d14,
  input  logic [DW-1:0]    fft_d15,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [3:0]       out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] out_frame,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int AW = PW + 4;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    fin [16];
  logic [DW-1:0]    mem [0:2**AW-1];
  logic [CNT_W-1:0] tag_mem [0:2**PW-1];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [OW-1:0]    occ, occ_pop, occ_nxt;
  logic [CNT_W-1:0] cap_tag;
  logic             beat, pop, accept;
  logic [3:0]       idx_nxt;
  logic [DW-1:0]    data_nxt;
  logic [CNT_W-1:0] frame_nxt;

  assign fin[0]  = fft_d0;
  assign fin[1]  = fft_d1;
  assign fin[2]  = fft_d2;
  assign fin[3]  = fft_d3;
  assign fin[4]  = fft_d4;
  assign fin[5]  = fft_d5;
  assign fin[6]  = fft_d6;
  assign fin[7]  = fft_d7;
  assign fin[8]  = fft_d8;
  assign fin[9]  = fft_d9;
  assign fin[10] = fft_d10;
  assign fin[11] = fft_d11;
  assign fin[12] = fft_d12;
  assign fin[13] = fft_d13;
  assign fin[14] = fft_d14;
  assign fin[15] = fft_d15;

  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (out_idx == 4'd15);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Occupancy bookkeeping: the final-bin pop frees its slot before this cycle's capture is judged
  always_comb begin
    beat    = (state == SEND) && out_ready;
    pop     = beat && (out_idx == 4'd15);
    occ_pop = occ - OW'(pop);
    accept  = fft_valid && (occ_pop < OW'(DEPTH));
    occ_nxt = occ_pop + OW'(accept);
    rd_nxt  = pop ? ptr_inc(rd_ptr) : rd_ptr;
  end

  // Output FSM; when the next frame is the one being captured right now, bin 0 bypasses the buffer
  always_comb begin
    state_nxt = state;
    idx_nxt   = out_idx;
    data_nxt  = out_data;
    frame_nxt = out_frame;
    if (state == IDLE || pop) begin
      idx_nxt = 4'd0;
      if (occ_pop != '0) begin
        state_nxt = SEND;
        data_nxt  = mem[{rd_nxt, 4'd0}];
        frame_nxt = tag_mem[rd_nxt];
      end else if (accept) begin
        state_nxt = SEND;
        data_nxt  = fin[0];
        frame_nxt = cap_tag;
      end else begin
        state_nxt = IDLE;
      end
    end else if (beat) begin
      idx_nxt  = out_idx + 4'd1;
      data_nxt = mem[{rd_ptr, out_idx + 4'd1}];
    end
  end

  // Control state, pointers, tag and drop accounting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_idx   <= '0;
      out_data  <= '0;
      out_frame <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      cap_tag   <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_idx   <= idx_nxt;
      out_data  <= data_nxt;
      out_frame <= frame_nxt;
      rd_ptr    <= rd_nxt;
      occ       <= occ_nxt;
      if (accept) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        cap_tag <= cap_tag + 1'b1;
      end else if (fft_valid) begin
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        overflow <= 1'b1;
      end
    end
  end

  // Frame storage: all 16 bins and the tag land in the slot at wr_ptr in one cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int b = 0; b < 16; b++) mem[{wr_ptr, 4'(b)}] <= fin[b];
      tag_mem[wr_ptr] <= cap_tag;
    end
  end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb/tb_fft_frame_serializer.sv - randomized self-checking bench for fft_frame_serializer
module tb_fft_frame_serializer;

  localparam int DEPTH = 2;

  typedef logic [31:0] frame_t [16];

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] din [16];
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic [7:0]  out_frame;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int checks;
  int failures;

  frame_t      fd;
  frame_t      mq[$];
  logic [7:0]  mtag_q[$];
  int          mpos;
  logic [7:0]  mtag;
  int          mdrops;
  logic        movf;

  fft_frame_serializer #(.DW(32), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(din[0]),   .fft_d1(din[1]),   .fft_d2(din[2]),   .fft_d3(din[3]),
    .fft_d4(din[4]),   .fft_d5(din[5]),   .fft_d6(din[6]),   .fft_d7(din[7]),
    .fft_d8(din[8]),   .fft_d9(din[9]),   .fft_d10(din[10]), .fft_d11(din[11]),
    .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_frame(out_frame),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a FIFO of whole frames; the head is visible from the cycle after its capture
  task automatic model_reset();
    mq.delete();
    mtag_q.delete();
    mpos = 0;
    mtag = 8'd0;
    mdrops = 0;
    movf = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic r);
    if (mq.size() > 0 && r) begin
      mpos++;
      if (mpos == 16) begin
        void'(mq.pop_front());
        void'(mtag_q.pop_front());
        mpos = 0;
      end
    end
    if (v) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(fd);
        mtag_q.push_back(mtag);
        mtag = mtag + 8'd1;
      end else begin
        if (mdrops < 255) mdrops++;
        movf = 1'b1;
      end
    end
  endtask

  function automatic logic [45:0] exp_vec();
    if (mq.size() == 0) return '0;
    return {1'b1, mpos == 15, 4'(mpos), mtag_q[0], mq[0][mpos]};
  endfunction

  function automatic logic [45:0] act_vec();
    return {out_valid, out_last, out_valid ? {out_idx, out_frame, out_data} : 44'd0};
  endfunction

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) fd[k] = $urandom;
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, return at the next falling edge
  task automatic cyc(input logic v, input logic r);
    fft_valid = v;
    out_ready = r;
    if (v) for (int k = 0; k < 16; k++) din[k] = fd[k];
    else   for (int k = 0; k < 16; k++) din[k] = $urandom;
    @(posedge clk);
    model_edge(v, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fft_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_last, overflow, out_idx, out_frame, drop_cnt, out_data} !== 55'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b l=%b ovf=%b idx=%0d fr=%0d drop=%0d data=%h exp all zero",
               out_valid, out_last, overflow, out_idx, out_frame, drop_cnt, out_data);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int k = 0; k < 16; k++) fd[k] = 32'h0001_0000 * k + k;
    for (int i = 0; i < 20; i++) begin
      cyc(i == 0, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_frame cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall_toggle();
    do_reset();
    rand_frame();
    for (int i = 0; i < 36; i++) begin
      cyc(i == 0, (i % 2) == 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stall_toggle cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || i == 3) rand_frame();
      cyc(i == 0 || i == 3, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL back_to_back_drop got=%0d exp=0", drop_cnt);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_frame();
      cyc(1'b1, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL overflow_fill cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd2}) begin
      failures++;
      $display("FAIL overflow_count got ovf=%b drop=%0d exp ovf=1 drop=2", overflow, drop_cnt);
    end
    for (int i = 0; i < 36; i++) begin
      cyc(1'b0, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL overflow_drain cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_pop_and_capture();
    logic done;
    logic v;
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_frame();
      cyc(1'b1, 1'b0);
    end
    for (int i = 0; i < 56; i++) begin
      v = !done && (mq.size() == DEPTH) && (mpos == 15);
      if (v) begin
        rand_frame();
        done = 1'b1;
      end
      cyc(v, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL pop_capture cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if ({done, overflow, drop_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL pop_capture_drop got done=%b ovf=%b drop=%0d exp done=1 ovf=0 drop=0",
               done, overflow, drop_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    do_reset();
    rand_frame();
    cyc(1'b1, 1'b1);
    guard = 0;
    while (mpos != 7 && guard < 40) begin
      cyc(1'b0, 1'b1);
      guard++;
    end
    checks++;
    if (mpos != 7 || out_idx !== 4'd7) begin
      failures++;
      $display("FAIL reset_mid_reach got idx=%0d exp idx=7", out_idx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_idx, out_frame} !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid_async got v=%b idx=%0d fr=%0d exp v=0 idx=0 fr=0",
               out_valid, out_idx, out_frame);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    rand_frame();
    for (int i = 0; i < 20; i++) begin
      cyc(i == 1, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic v;
    logic r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 3) != 0);
      if (v) rand_frame();
      cyc(v, r);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if ({overflow, drop_cnt} !== {movf, 8'(mdrops)}) begin
      failures++;
      $display("FAIL random_drop got ovf=%b drop=%0d exp ovf=%b drop=%0d", overflow, drop_cnt, movf, mdrops);
    end
  endtask

  task automatic test_tag_wrap();
    do_reset();
    for (int i = 0; i < 260 * 17; i++) begin
      if (i % 17 == 0) rand_frame();
      cyc(i % 17 == 0, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL tag_wrap cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int i = 0; i < 262; i++) begin
      rand_frame();
      cyc(1'b1, 1'b0);
    end
    checks++;
    if ({overflow, drop_cnt} !== {1'b1, 8'hFF} || mdrops != 255) begin
      failures++;
      $display("FAIL drop_saturate got ovf=%b drop=%0d exp ovf=1 drop=255", overflow, drop_cnt);
    end
    for (int i = 0; i < 36; i++) begin
      cyc(1'b0, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL drop_saturate_drain cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    fft_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) din[k] = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_stall_toggle();
    test_back_to_back();
    test_overflow();
    test_pop_and_capture();
    test_reset_mid_frame();
    test_random();
    test_tag_wrap();
    test_drop_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
